// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// well-known source indices and default sizing.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int IRQ_NUM_SRC = 4;
    localparam int IRQ_VEC_W   = 2;

    localparam int IRQ_TIMER = 0;
    localparam int IRQ_PS2   = 1;
    localparam int IRQ_VGA   = 2;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake bundle between the controller and the core.
interface irq_controller_if
    import irq_pkg::*;
#(
    parameter int VEC_W = IRQ_VEC_W
);
    // Handshake: cpu_irq is a level "valid" that the controller holds with
    // cpu_vector frozen until the core answers with a one-cycle cpu_ack;
    // cpu_ack while cpu_irq is low carries no meaning and is ignored.
    logic             cpu_irq;
    logic [VEC_W-1:0] cpu_vector;
    logic             cpu_ack;

    modport master (output cpu_irq, output cpu_vector, input cpu_ack);
    modport slave  (input cpu_irq, input cpu_vector, output cpu_ack);

endinterface

// File: rtl/irq_priority_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module irq_priority_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC,
    parameter int VEC_W   = IRQ_VEC_W
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [VEC_W-1:0]   idx
);

    // Scan from the top down so the lowest index is the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Masks and prioritises level interrupt requests, presents one vector to the
// CPU, and returns a one-cycle ack to the serviced source.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC,
    parameter int VEC_W   = IRQ_VEC_W,
    parameter int HOLDOFF = 2
) (
    input  logic               clk_50Mhz,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic [NUM_SRC-1:0] src_ack,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    output logic [NUM_SRC-1:0] mask_q,
    output logic [NUM_SRC-1:0] pending,
    irq_controller_if.master   cpu,
    output state_t             state
);

    localparam int CNT_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    state_t             state_next;
    logic               presenting, irq_next;
    logic [VEC_W-1:0]   vector, vec_next;
    logic [NUM_SRC-1:0] ack_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [VEC_W-1:0]   last_src, last_next;
    logic [NUM_SRC-1:0] blocked;
    logic               enc_any;
    logic [VEC_W-1:0]   enc_idx;

    assign cpu.cpu_irq    = presenting;
    assign cpu.cpu_vector = vector;

    // Ignore the just-acked line while it is still on its way down.
    assign blocked = (cnt != '0) ? (NUM_SRC'(1) << last_src) : '0;

    irq_priority_enc #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_enc (
        .req (pending),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_comb begin
        state_next = state;
        irq_next   = presenting;
        vec_next   = vector;
        ack_next   = '0;
        cnt_next   = cnt;
        last_next  = last_src;
        unique case (state)
            ST_IDLE: begin
                if (enc_any) begin
                    vec_next   = enc_idx;
                    irq_next   = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (cpu.cpu_ack) begin
                    irq_next   = 1'b0;
                    ack_next   = NUM_SRC'(1) << vector;
                    last_next  = vector;
                    cnt_next   = CNT_W'(HOLDOFF);
                    state_next = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state      <= ST_IDLE;
            presenting <= 1'b0;
            vector     <= '0;
            src_ack    <= '0;
            cnt        <= '0;
            last_src   <= '0;
            mask_q     <= '1;
            pending    <= '0;
        end else begin
            state      <= state_next;
            presenting <= irq_next;
            vector     <= vec_next;
            src_ack    <= ack_next;
            cnt        <= cnt_next;
            last_src   <= last_next;
            pending    <= irq_in & mask_q & ~blocked;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a random
// run compared against a timestamp-based reference model.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int VEC_W   = 2;
    localparam int HOLDOFF = 2;

    logic               clk_50Mhz = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] src_ack;
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_data;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pending;
    state_t             state;

    irq_controller_if #(.VEC_W(VEC_W)) cpu_bus ();

    irq_controller #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .irq_in    (irq_in),
        .src_ack   (src_ack),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .mask_q    (mask_q),
        .pending   (pending),
        .cpu       (cpu_bus),
        .state     (state)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tracks edges by number and remembers when the
    // controller is free again and until which edge a source is ignored.
    int               m_cyc = 0;
    int               m_free_from = 0;
    int               m_block_end = -1;
    int               m_bsrc = 0;
    logic [NUM_SRC-1:0] m_mask = '1;
    logic [NUM_SRC-1:0] m_pend = '0;
    logic [NUM_SRC-1:0] m_ack = '0;
    logic             m_irq = 1'b0;
    logic [VEC_W-1:0] m_vec = '0;

    function automatic int lowest_set(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        logic [NUM_SRC-1:0] blk;
        logic [NUM_SRC-1:0] new_pend;
        m_ack = '0;
        if (rst) begin
            m_mask = '1; m_pend = '0; m_irq = 1'b0; m_vec = '0;
            m_free_from = m_cyc + 1;
            m_block_end = m_cyc;
        end else begin
            blk      = (m_cyc <= m_block_end) ? NUM_SRC'(1 << m_bsrc) : '0;
            new_pend = irq_in & m_mask & ~blk;
            if (m_irq) begin
                if (cpu_bus.cpu_ack) begin
                    m_ack       = NUM_SRC'(1 << m_vec);
                    m_irq       = 1'b0;
                    m_bsrc      = int'(m_vec);
                    m_block_end = m_cyc + HOLDOFF;
                    m_free_from = m_cyc + ((HOLDOFF == 0) ? 1 : HOLDOFF + 1);
                end
            end else if (m_cyc >= m_free_from && m_pend != '0) begin
                m_vec = VEC_W'(lowest_set(m_pend));
                m_irq = 1'b1;
            end
            m_pend = new_pend;
            if (mask_wr) m_mask = mask_data;
        end
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk_50Mhz);
        model_step();
        @(negedge clk_50Mhz);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0) begin n_err++; $display("FAIL reset_cpu_irq: got %b expected 0", cpu_bus.cpu_irq); end
        n_cmp++; if (cpu_bus.cpu_vector !== 2'd0) begin n_err++; $display("FAIL reset_vector: got %0d expected 0", cpu_bus.cpu_vector); end
        n_cmp++; if (src_ack !== 4'b0000) begin n_err++; $display("FAIL reset_src_ack: got %b expected 0000", src_ack); end
        n_cmp++; if (mask_q !== 4'b1111) begin n_err++; $display("FAIL reset_mask_q: got %b expected 1111", mask_q); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
    endtask

    task automatic test_basic();
        irq_in = 4'b0001;
        tick();
        n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL basic_pending: got %b expected 0001", pending); end
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0) begin n_err++; $display("FAIL basic_latency: got %b expected 0", cpu_bus.cpu_irq); end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd0) begin n_err++; $display("FAIL basic_present: got irq=%b vec=%0d expected irq=1 vec=0", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        tick(); tick();
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; irq_in = 4'b0000;
        n_cmp++; if (src_ack !== 4'b0001 || cpu_bus.cpu_irq !== 1'b0) begin n_err++; $display("FAIL basic_ack: got ack=%b irq=%b expected ack=0001 irq=0", src_ack, cpu_bus.cpu_irq); end
        tick();
        n_cmp++; if (src_ack !== 4'b0000) begin n_err++; $display("FAIL basic_ack_width: got %b expected 0000", src_ack); end
        repeat (4) tick();
    endtask

    task automatic test_priority();
        irq_in = 4'b0110;
        tick(); tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd1) begin n_err++; $display("FAIL prio_first: got irq=%b vec=%0d expected irq=1 vec=1", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        irq_in = 4'b0111;
        tick(); tick();
        n_cmp++; if (cpu_bus.cpu_vector !== 2'd1) begin n_err++; $display("FAIL prio_no_preempt: got vec=%0d expected 1", cpu_bus.cpu_vector); end
        irq_in = 4'b0110; cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; irq_in = 4'b0100;
        n_cmp++; if (src_ack !== 4'b0010) begin n_err++; $display("FAIL prio_ack: got %b expected 0010", src_ack); end
        tick(); tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0) begin n_err++; $display("FAIL prio_holdoff_quiet: got %b expected 0", cpu_bus.cpu_irq); end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd2) begin n_err++; $display("FAIL prio_second: got irq=%b vec=%0d expected irq=1 vec=2", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; irq_in = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_data = 4'b1110;
        tick();
        mask_wr = 1'b0;
        n_cmp++; if (mask_q !== 4'b1110) begin n_err++; $display("FAIL mask_load: got %b expected 1110", mask_q); end
        irq_in = 4'b0001;
        tick(); tick(); tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0 || pending !== 4'b0000) begin n_err++; $display("FAIL mask_block: got irq=%b pend=%b expected irq=0 pend=0000", cpu_bus.cpu_irq, pending); end
        mask_wr = 1'b1; mask_data = 4'b1111;
        tick();
        mask_wr = 1'b0;
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0) begin n_err++; $display("FAIL mask_unmask_early: got %b expected 0", cpu_bus.cpu_irq); end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd0) begin n_err++; $display("FAIL mask_unmask: got irq=%b vec=%0d expected irq=1 vec=0", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        mask_wr = 1'b1; mask_data = 4'b0000; irq_in = 4'b0000;
        tick();
        mask_wr = 1'b0;
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd0) begin n_err++; $display("FAIL mask_no_cancel: got irq=%b vec=%0d expected irq=1 vec=0", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; mask_wr = 1'b1; mask_data = 4'b1111;
        n_cmp++; if (src_ack !== 4'b0001) begin n_err++; $display("FAIL mask_masked_ack: got %b expected 0001", src_ack); end
        tick();
        mask_wr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_refire();
        irq_in = 4'b0100;
        tick(); tick();
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0;
        n_cmp++; if (src_ack !== 4'b0100) begin n_err++; $display("FAIL refire_ack: got %b expected 0100", src_ack); end
        for (int k = 1; k <= HOLDOFF + 1; k++) begin
            tick();
            n_cmp++; if (cpu_bus.cpu_irq !== 1'b0 || src_ack !== 4'b0000) begin n_err++; $display("FAIL refire_gap%0d: got irq=%b ack=%b expected irq=0 ack=0000", k, cpu_bus.cpu_irq, src_ack); end
        end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd2) begin n_err++; $display("FAIL refire_again: got irq=%b vec=%0d expected irq=1 vec=2", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; irq_in = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_stray_ack();
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0;
        n_cmp++; if (src_ack !== 4'b0000 || state !== ST_IDLE) begin n_err++; $display("FAIL stray_idle: got ack=%b state=%0d expected ack=0000 state=%0d", src_ack, state, ST_IDLE); end
        irq_in = 4'b1000;
        tick(); tick();
        cpu_bus.cpu_ack = 1'b1;
        tick();
        irq_in = 4'b0000;
        n_cmp++; if (src_ack !== 4'b1000) begin n_err++; $display("FAIL stray_real_ack: got %b expected 1000", src_ack); end
        tick();
        cpu_bus.cpu_ack = 1'b0;
        n_cmp++; if (src_ack !== 4'b0000 || state !== ST_HOLDOFF) begin n_err++; $display("FAIL stray_holdoff: got ack=%b state=%0d expected ack=0000 state=%0d", src_ack, state, ST_HOLDOFF); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        mask_wr = 1'b1; mask_data = 4'b0111;
        tick();
        mask_wr = 1'b0; irq_in = 4'b0010;
        tick(); tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd1) begin n_err++; $display("FAIL rstmid_present: got irq=%b vec=%0d expected irq=1 vec=1", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        rst = 1'b1; cpu_bus.cpu_ack = 1'b1;
        tick();
        rst = 1'b0; cpu_bus.cpu_ack = 1'b0;
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0 || src_ack !== 4'b0000 || mask_q !== 4'b1111) begin n_err++; $display("FAIL rstmid_abort: got irq=%b ack=%b mask=%b expected irq=0 ack=0000 mask=1111", cpu_bus.cpu_irq, src_ack, mask_q); end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b0 || src_ack !== 4'b0000) begin n_err++; $display("FAIL rstmid_quiet: got irq=%b ack=%b expected irq=0 ack=0000", cpu_bus.cpu_irq, src_ack); end
        tick();
        n_cmp++; if (cpu_bus.cpu_irq !== 1'b1 || cpu_bus.cpu_vector !== 2'd1) begin n_err++; $display("FAIL rstmid_represent: got irq=%b vec=%0d expected irq=1 vec=1", cpu_bus.cpu_irq, cpu_bus.cpu_vector); end
        cpu_bus.cpu_ack = 1'b1;
        tick();
        cpu_bus.cpu_ack = 1'b0; irq_in = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] prev_ack = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NUM_SRC; b++) begin
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            end
            cpu_bus.cpu_ack = ($urandom_range(0, 3) == 0);
            mask_wr         = ($urandom_range(0, 19) == 0);
            mask_data       = NUM_SRC'($urandom_range(0, 15));
            rst             = ($urandom_range(0, 149) == 0);
            tick();
            n_cmp++; if (cpu_bus.cpu_irq !== m_irq) begin n_err++; $display("FAIL rand_irq@%0d: got %b expected %b", n, cpu_bus.cpu_irq, m_irq); end
            if (m_irq) begin
                n_cmp++; if (cpu_bus.cpu_vector !== m_vec) begin n_err++; $display("FAIL rand_vec@%0d: got %0d expected %0d", n, cpu_bus.cpu_vector, m_vec); end
            end
            n_cmp++; if (src_ack !== m_ack) begin n_err++; $display("FAIL rand_ack@%0d: got %b expected %b", n, src_ack, m_ack); end
            n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rand_pend@%0d: got %b expected %b", n, pending, m_pend); end
            n_cmp++; if (mask_q !== m_mask) begin n_err++; $display("FAIL rand_mask@%0d: got %b expected %b", n, mask_q, m_mask); end
            n_cmp++; if ($countones(src_ack) > 1 || (src_ack != '0 && prev_ack != '0)) begin n_err++; $display("FAIL rand_ack_shape@%0d: got %b after %b expected one-hot, not back-to-back", n, src_ack, prev_ack); end
            prev_ack = src_ack;
        end
        rst = 1'b0; cpu_bus.cpu_ack = 1'b0; mask_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
        cpu_bus.cpu_ack = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_refire();
        test_stray_ack();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
